// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming instruction,
// captured into a 2-entry elastic buffer (output register + skid register)
// so fetch sees full throughput while execute applies back-pressure.
module decode_stage #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [WORD_SIZE-1:0] in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_pc,
   output logic [3:0]           alu_op,
   output logic                 a_sel_pc,
   output logic                 b_sel_imm,
   output logic [WORD_SIZE-1:0] imm,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic                 reg_write,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 branch,
   output logic                 jump,
   output logic [2:0]           funct3,
   output logic                 illegal
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // One decoded bundle as it travels through the buffer.
   typedef struct packed {
      logic [3:0]           alu_op;
      logic                 a_sel_pc;
      logic                 b_sel_imm;
      logic [WORD_SIZE-1:0] imm;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
      logic                 branch;
      logic                 jump;
      logic [2:0]           funct3;
      logic                 illegal;
      logic [WORD_SIZE-1:0] pc;
   } bundle_t;

   bundle_t dec_d;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic        ill;
   logic        accept, drain;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
   assign imm_sh = {27'b0, in_instr[24:20]};

   // Combinational decode of the instruction currently offered by fetch.
   // b_sel_imm is set wherever the immediate is the ALU B operand; LUI and
   // AUIPC write rd like every other result-producing format.
   always_comb begin
      dec_d        = '0;
      dec_d.rs1    = in_instr[19:15];
      dec_d.rs2    = in_instr[24:20];
      dec_d.rd     = in_instr[11:7];
      dec_d.funct3 = f3;
      dec_d.pc     = in_pc;
      dec_d.alu_op = ALU_ADD;
      ill          = 1'b0;
      if (in_instr[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (opc)
            OPC_OP: begin
               dec_d.reg_write = 1'b1;
               if (f7 == F7_BASE) begin
                  case (f3)
                     3'b000:  dec_d.alu_op = ALU_ADD;
                     3'b001:  dec_d.alu_op = ALU_SLL;
                     3'b010:  dec_d.alu_op = ALU_SLT;
                     3'b011:  dec_d.alu_op = ALU_SLTU;
                     3'b100:  dec_d.alu_op = ALU_XOR;
                     3'b101:  dec_d.alu_op = ALU_SRL;
                     3'b110:  dec_d.alu_op = ALU_OR;
                     default: dec_d.alu_op = ALU_AND;
                  endcase
               end else if (f7 == F7_ALT && f3 == 3'b000) begin
                  dec_d.alu_op = ALU_SUB;
               end else if (f7 == F7_ALT && f3 == 3'b101) begin
                  dec_d.alu_op = ALU_SRA;
               end else begin
                  ill = 1'b1;
               end
            end
            OPC_OPIMM: begin
               dec_d.reg_write = 1'b1;
               dec_d.b_sel_imm = 1'b1;
               dec_d.imm       = imm_i;
               case (f3)
                  3'b000: dec_d.alu_op = ALU_ADD;
                  3'b010: dec_d.alu_op = ALU_SLT;
                  3'b011: dec_d.alu_op = ALU_SLTU;
                  3'b100: dec_d.alu_op = ALU_XOR;
                  3'b110: dec_d.alu_op = ALU_OR;
                  3'b111: dec_d.alu_op = ALU_AND;
                  3'b001: begin
                     dec_d.alu_op = ALU_SLL;
                     dec_d.imm    = imm_sh;
                     ill          = (f7 != F7_BASE);
                  end
                  default: begin
                     dec_d.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                     dec_d.imm    = imm_sh;
                     ill          = (f7 != F7_BASE) && (f7 != F7_ALT);
                  end
               endcase
            end
            OPC_LUI: begin
               dec_d.alu_op    = ALU_PASS;
               dec_d.b_sel_imm = 1'b1;
               dec_d.reg_write = 1'b1;
               dec_d.imm       = imm_u;
            end
            OPC_AUIPC: begin
               dec_d.a_sel_pc  = 1'b1;
               dec_d.b_sel_imm = 1'b1;
               dec_d.reg_write = 1'b1;
               dec_d.imm       = imm_u;
            end
            OPC_LOAD: begin
               dec_d.b_sel_imm = 1'b1;
               dec_d.reg_write = 1'b1;
               dec_d.mem_read  = 1'b1;
               dec_d.imm       = imm_i;
            end
            OPC_STORE: begin
               dec_d.b_sel_imm = 1'b1;
               dec_d.mem_write = 1'b1;
               dec_d.imm       = imm_s;
            end
            OPC_BRANCH: begin
               dec_d.branch = 1'b1;
               dec_d.imm    = imm_b;
               case (f3[2:1])
                  2'b00:   dec_d.alu_op = ALU_SUB;
                  2'b10:   dec_d.alu_op = ALU_SLT;
                  2'b11:   dec_d.alu_op = ALU_SLTU;
                  default: ill = 1'b1;
               endcase
            end
            OPC_JAL: begin
               dec_d.jump      = 1'b1;
               dec_d.reg_write = 1'b1;
               dec_d.a_sel_pc  = 1'b1;
               dec_d.b_sel_imm = 1'b1;
               dec_d.imm       = imm_j;
            end
            OPC_JALR: begin
               dec_d.jump      = 1'b1;
               dec_d.reg_write = 1'b1;
               dec_d.b_sel_imm = 1'b1;
               dec_d.imm       = imm_i;
               ill             = (f3 != 3'b000);
            end
            default: ill = 1'b1;
         endcase
      end
      // Illegal bundles still flow downstream but must not cause side effects.
      if (ill) begin
         dec_d.illegal   = 1'b1;
         dec_d.alu_op    = ALU_PASS;
         dec_d.a_sel_pc  = 1'b0;
         dec_d.b_sel_imm = 1'b0;
         dec_d.imm       = '0;
         dec_d.reg_write = 1'b0;
         dec_d.mem_read  = 1'b0;
         dec_d.mem_write = 1'b0;
         dec_d.branch    = 1'b0;
         dec_d.jump      = 1'b0;
      end
   end

   assign in_ready = rst_n && !skid_valid_q;
   assign accept   = in_valid && in_ready;
   assign drain    = !out_valid_q || out_ready;

   // Elastic buffer next state: skid refills the output first, so order holds.
   // An accept never coincides with a full skid because in_ready is low then.
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec_d;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec_d;
         skid_valid_d = 1'b1;
      end
   end

   // Buffer registers with synchronous reset clearing valids and all fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_q.pc;
   assign alu_op    = out_q.alu_op;
   assign a_sel_pc  = out_q.a_sel_pc;
   assign b_sel_imm = out_q.b_sel_imm;
   assign imm       = out_q.imm;
   assign rs1       = out_q.rs1;
   assign rs2       = out_q.rs2;
   assign rd        = out_q.rd;
   assign reg_write = out_q.reg_write;
   assign mem_read  = out_q.mem_read;
   assign mem_write = out_q.mem_write;
   assign branch    = out_q.branch;
   assign jump      = out_q.jump;
   assign funct3    = out_q.funct3;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, back-pressure, flush,
// then randomized traffic checked against a behavioural decode model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, imm;
   logic [3:0]  alu_op;
   logic        a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;

   int checks = 0;
   int errors = 0;
   int n_pop  = 0;

   typedef struct packed {
      logic [3:0]  alu;
      logic        asel;
      logic        bsel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        jp;
      logic [2:0]  f3;
      logic        ill;
      logic [31:0] pc;
   } bund_t;

   bund_t exp_q[$];

   // ALU code for the base-encoding register/immediate ops, indexed by funct3.
   localparam logic [3:0] RTAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
   localparam logic [3:0] PASS = 4'd10;

   decode_stage #(.WORD_SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .alu_op(alu_op), .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm), .imm(imm),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .jump(jump), .funct3(funct3), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference decode built from the ISA field layout using plain arithmetic.
   function automatic bund_t model(input logic [31:0] i, input logic [31:0] pc);
      bund_t e;
      logic [31:0] si, s_imm, b_imm, u_imm, j_imm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        legal;
      si    = $signed(i) >>> 20;
      s_imm = (si & ~32'h1F) | {27'b0, i[11:7]};
      b_imm = (s_imm & ~32'h801) | ({31'b0, i[7]} << 11);
      u_imm = i & 32'hFFFFF000;
      j_imm = (si & 32'hFFF007FE) | (i & 32'h000FF000) | ({31'b0, i[20]} << 11);
      f7 = i[31:25];
      f3 = i[14:12];
      e = '0;
      e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3; e.pc = pc;
      legal = 1'b0;
      if (i[1:0] == 2'b11) begin
         case (i[6:0])
            7'h33: begin
               e.rw = 1;
               if (f7 == 0) begin legal = 1; e.alu = RTAB[f3]; end
               else if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.alu = 4'd1; end
               else if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.alu = 4'd7; end
            end
            7'h13: begin
               e.rw = 1; e.bsel = 1;
               if (f3 == 1) begin
                  legal = (f7 == 0); e.alu = 4'd2; e.imm = {27'b0, i[24:20]};
               end else if (f3 == 5) begin
                  legal = (f7 == 0) || (f7 == 7'h20);
                  e.alu = (f7 == 7'h20) ? 4'd7 : 4'd6; e.imm = {27'b0, i[24:20]};
               end else begin
                  legal = 1; e.alu = RTAB[f3]; e.imm = si;
               end
            end
            7'h37: begin legal = 1; e.alu = PASS; e.bsel = 1; e.rw = 1; e.imm = u_imm; end
            7'h17: begin legal = 1; e.alu = 0; e.asel = 1; e.bsel = 1; e.rw = 1; e.imm = u_imm; end
            7'h03: begin legal = 1; e.bsel = 1; e.rw = 1; e.mr = 1; e.imm = si; end
            7'h23: begin legal = 1; e.bsel = 1; e.mw = 1; e.imm = s_imm; end
            7'h63: begin
               e.br = 1; e.imm = b_imm;
               if (f3 <= 1) begin legal = 1; e.alu = 4'd1; end
               else if (f3 == 4 || f3 == 5) begin legal = 1; e.alu = 4'd3; end
               else if (f3 >= 6) begin legal = 1; e.alu = 4'd4; end
            end
            7'h6F: begin legal = 1; e.jp = 1; e.rw = 1; e.asel = 1; e.bsel = 1; e.imm = j_imm; end
            7'h67: begin legal = (f3 == 0); e.jp = 1; e.rw = 1; e.bsel = 1; e.imm = si; end
            default: legal = 1'b0;
         endcase
      end
      if (!legal) begin
         e.ill = 1; e.alu = PASS;
         e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h00};
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 9);
      r[6:0] = (k == 9) ? r[6:0] : ops[k];
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      if ($urandom_range(0, 15) != 0 && k != 9) r[1:0] = 2'b11;
      return r;
   endfunction

   // Scoreboard feeder: records the expected bundle for each accept.
   always @(negedge clk) begin
      if (!rst_n || flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
   end

   // Monitor: compares every bundle execute consumes against the scoreboard.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         bund_t a, e;
         a = '{alu_op, a_sel_pc, b_sel_imm, imm, rs1, rs2, rd, reg_write, mem_read,
               mem_write, branch, jump, funct3, illegal, out_pc};
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bundle: got %0h expected none", a);
         end else begin
            e = exp_q.pop_front();
            n_pop++;
            if (e.ill) begin
               a.imm = '0; a.asel = 0; a.bsel = 0;
               e.imm = '0; e.asel = 0; e.bsel = 0;
            end
            chk("bundle", 128'(a), 128'(e));
         end
      end
   end

   // Offer one instruction and hold it until accepted (called at posedge+1).
   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      bit done = 0;
      int n = 0;
      in_valid = 1; in_instr = ins; in_pc = pc;
      while (!done && n < 50) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int p0;
      rst_n = 0; flush = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1;

      // Reset holds everything clear even with fetch offering.
      repeat (3) begin
         @(negedge clk);
         chk("reset.out_valid", out_valid, 0);
         chk("reset.in_ready", in_ready, 0);
         chk("reset.fields", {alu_op, a_sel_pc, b_sel_imm, imm, rs1, rs2, rd, reg_write,
             mem_read, mem_write, branch, jump, funct3, illegal, out_pc}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1; in_valid = 0;
      @(negedge clk);
      chk("post_reset.in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed vectors, one-cycle latency.
      issue(32'h002081B3, 32'h100); in_valid = 0; @(negedge clk);
      chk("add.out_valid", out_valid, 1);
      chk("add.fields", {alu_op, rs1, rs2, rd, reg_write, b_sel_imm}, {4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0});
      @(posedge clk); #1;
      issue(32'hFFF00093, 32'h104); in_valid = 0; @(negedge clk);
      chk("addi.fields", {imm, b_sel_imm}, {32'hFFFFFFFF, 1'b1});
      @(posedge clk); #1;
      issue(32'h4030D093, 32'h108); in_valid = 0; @(negedge clk);
      chk("srai.fields", {alu_op, imm}, {4'd7, 32'h3});
      @(posedge clk); #1;
      issue(32'h123452B7, 32'h10C); in_valid = 0; @(negedge clk);
      chk("lui.fields", {alu_op, imm, rd}, {4'd10, 32'h12345000, 5'd5});
      @(posedge clk); #1;
      issue(32'h0020C463, 32'h110); in_valid = 0; @(negedge clk);
      chk("blt.fields", {alu_op, branch, imm, reg_write}, {4'd3, 1'b1, 32'h8, 1'b0});
      @(posedge clk); #1;
      issue(32'h00000000, 32'h114); in_valid = 0; @(negedge clk);
      chk("zero.fields", {illegal, reg_write, mem_read, mem_write, branch, jump}, 6'b100000);
      @(posedge clk); #1;
      idle(3);

      // Back-pressure: four instructions while execute stalls for three cycles.
      p0 = n_pop;
      fork
         begin
            issue(32'h00308133, 32'h200);
            issue(32'h00A00513, 32'h204);
            issue(32'h0000A183, 32'h208);
            issue(32'h0041A023, 32'h20C);
            in_valid = 0;
         end
         begin
            @(posedge clk); #1; out_ready = 0;
            @(posedge clk);
            @(negedge clk);
            chk("bp.in_ready_low", in_ready, 0);
            chk("bp.out_valid", out_valid, 1);
            @(posedge clk);
            @(posedge clk); #1; out_ready = 1;
         end
      join
      idle(6);
      chk("bp.popped", n_pop - p0, 4);
      chk("bp.queue_empty", exp_q.size(), 0);

      // Flush with output and skid full while fetch still offers a third.
      out_ready = 0;
      issue(32'h00100093, 32'h300);
      issue(32'h00200113, 32'h304);
      in_valid = 1; in_instr = 32'h00300193; in_pc = 32'h308; flush = 1;
      @(negedge clk);
      chk("flush1.pre_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      @(negedge clk);
      chk("flush1.out_valid", out_valid, 0);
      chk("flush1.in_ready", in_ready, 1);
      @(posedge clk); #1;
      out_ready = 1;
      idle(4);
      @(negedge clk);
      chk("flush1.nothing_emerges", out_valid, 0);
      @(posedge clk); #1;

      // Flush against a stalled output with a same-cycle accept.
      out_ready = 0;
      issue(32'h00400213, 32'h400);
      in_valid = 1; in_instr = 32'h00500293; in_pc = 32'h404; flush = 1;
      @(negedge clk);
      chk("flush2.pre_in_ready", in_ready, 1);
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      @(negedge clk);
      chk("flush2.out_valid", out_valid, 0);
      @(posedge clk); #1;
      out_ready = 1;
      idle(4);
      @(negedge clk);
      chk("flush2.nothing_emerges", out_valid, 0);
      @(posedge clk); #1;

      // Randomized traffic with random back-pressure and occasional flushes.
      for (int c = 0; c < 2000; c++) begin
         bit fl;
         fl        = ($urandom_range(0, 49) == 0);
         flush     = fl;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = gen_instr();
         in_pc     = $urandom & 32'hFFFFFFFC;
         out_ready = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      flush = 0; in_valid = 0; out_ready = 1;
      idle(5);
      @(negedge clk);
      chk("random.queue_empty", exp_q.size(), 0);
      chk("random.out_valid_idle", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction decode stage sitting between fetch and execute. It accepts one 32-bit instruction plus its PC per valid/ready handshake and produces the ALU opcode, operand-select controls, the sign-extended immediate, register addresses and memory/branch controls for the execute stage. A 2-entry elastic buffer (output register + skid register) decouples fetch from execute back-pressure at full throughput. An illegal-instruction flag travels down the pipe with the instruction.

## Interface
- WORD_SIZE, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous pipeline kill; discards all held and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals rst_n && !skid_valid.
- in_instr  in  32  raw instruction.
- in_pc  in  WORD_SIZE  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  WORD_SIZE  PC of the decoded instruction.
- alu_op  out  4  ALU_OP_* code: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS=10 (defines.vh values).
- a_sel_pc  out  1  ALU A = PC (else rs1 data).
- b_sel_imm  out  1  ALU B = imm (else rs2 data).
- imm  out  WORD_SIZE  decoded immediate.
- rs1, rs2, rd  out  5 each  register addresses (instr[19:15], [24:20], [11:7]).
- reg_write, mem_read, mem_write, branch, jump  out  1 each  control.
- funct3  out  3  instr[14:12] passthrough (load/store size, branch condition).
- illegal  out  1  instruction not decodable.

## Operation
- Decode (combinational on the incoming instruction, captured into a register on accept):
  - OP 0110011: b_sel_imm=0, reg_write=1; funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; funct7=0100000 selects SUB (funct3 000) or SRA (101); any other funct7 -> illegal.
  - OP-IMM 0010011: b_sel_imm=1, reg_write=1, I-imm sign-extended. SLLI/SRLI/SRAI: imm = {27'b0, shamt}; funct7 must be 0000000 (SRAI: 0100000), else illegal.
  - LUI 0110111: PASS, U-imm. AUIPC 0010111: ADD, a_sel_pc=1, U-imm.
  - LOAD 0000011: ADD, I-imm, mem_read=1, reg_write=1. STORE 0100011: ADD, S-imm, mem_write=1.
  - BRANCH 1100011: branch=1, B-imm; funct3 000/001 -> SUB, 100/101 -> SLT, 110/111 -> SLTU, 010/011 -> illegal.
  - JAL 1101111: jump=1, reg_write=1, a_sel_pc=1, ADD, J-imm. JALR 1100111 (funct3 must be 000): jump=1, reg_write=1, ADD, I-imm.
  - Any other opcode, or instr[1:0]!=11: illegal=1.
- Illegal bundles: reg_write, mem_read, mem_write, branch, jump forced 0; alu_op=PASS; still forwarded with out_valid.
- Buffer: accept when in_valid && in_ready. If output register empty or being consumed this cycle, load it; otherwise load skid. When output consumed and skid full, skid moves to output.
- Order preserved; no bundle duplicated or dropped except on flush.

## Timing
- Latency 1 cycle: accepted at edge N -> out_valid at N+1.
- Throughput 1/cycle with out_ready held high.
- in_ready drops the cycle after an accept collides with a stalled output (skid filled); rises the cycle after the output drains.
- Reset (rst_n low at edge): out_valid=0, skid_valid=0, all output fields 0; in_ready=0 while rst_n low.
- flush at edge: out_valid=0, skid_valid=0; an instruction accepted in the same cycle is discarded. Reset and flush together behave as reset.
- Output fields stable while out_valid && !out_ready.

## Test plan
- Reset: rst_n low 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, all fields 0; first cycle after, in_ready=1.
- 0x002081B3 (add x3,x1,x2) -> next cycle alu_op=0, rs1=1, rs2=2, rd=3, reg_write=1, b_sel_imm=0; 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, b_sel_imm=1.
- 0x4030D093 (srai x1,x1,3) -> alu_op=7, imm=0x00000003; 0x123452B7 (lui x5,0x12345) -> alu_op=10, imm=0x12345000, rd=5.
- 0x0020C463 (blt x1,x2,+8) -> alu_op=3, branch=1, imm=8, reg_write=0; 0x00000000 -> illegal=1, all controls 0.
- Back-pressure: stream 4 instructions, out_ready low cycles 2-4 -> in_ready low after skid fills, all 4 emerge in order, none lost.
- Flush with output and skid full plus concurrent accept -> out_valid=0 next cycle, in_ready=1, none of the 3 instructions emerge.
